// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone bus arbiters.
//
// Contents:
//   arb_state_e  arbiter state (StIdle: no grant, StBusy: one-hot grant held)
//   ARB_NM_MAX   largest master count any arbiter built on this package supports
//   rr_next      rotating-priority pick: first requester after 'last', one-hot result

package wb_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_NM_MAX = 8;
    localparam int unsigned ARB_IDX_W  = 3;

    // Scans last+1, last+2, ... (mod nm) and returns the first requester as a
    // one-hot vector; all-zero when nothing requests. Only bits [nm-1:0] are used.
    function automatic logic [ARB_NM_MAX-1:0] rr_next(
        input logic [ARB_NM_MAX-1:0] req,
        input int unsigned           nm,
        input int unsigned           last
    );
        logic [ARB_NM_MAX-1:0] gnt;
        int unsigned           idx;
        gnt = '0;
        for (int unsigned k = 1; k <= ARB_NM_MAX; k++) begin
            idx = (last + k) % nm;
            if (k <= nm && gnt == '0 && req[idx[ARB_IDX_W-1:0]]) begin
                gnt[idx[ARB_IDX_W-1:0]] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotating-priority picker.
//
// Ports:
//   req   in   NM  request vector
//   last  in   LW  index of the most recently served requester
//   gnt   out  NM  one-hot pick, first requester after 'last' (wrapping)
//   any   out  1   at least one request present (gnt is non-zero)

module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NM = 3,
    parameter int unsigned LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [LW-1:0] last,
    output logic [NM-1:0] gnt,
    output logic          any
);

    logic [ARB_NM_MAX-1:0] req_ext;
    logic [ARB_NM_MAX-1:0] gnt_ext;
    logic                  unused_gnt_ext;

    always_comb begin
        req_ext         = '0;
        req_ext[NM-1:0] = req;
    end

    assign gnt_ext = rr_next(req_ext, NM, 32'(last));
    assign gnt     = gnt_ext[NM-1:0];
    assign any     = |req;

    // Upper bits are always zero because requests there are padded off.
    assign unused_gnt_ext = ^gnt_ext;

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share the single slave port of the
// memory controller. The grant is held for a whole bus cycle (CYC high), so
// block and read-modify-write cycles stay atomic; masters rotate fairly.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   Defined:   watchdog aborts a slave access stalled for TO cycles, pulses
//              ERR to the granted master once and sets sticky to_o.
//   Undefined: no watchdog, to_o tied 0, a stalled slave holds the grant.
//
// Ports:
//   clk_i              in   clock, rising edge
//   arst_i             in   asynchronous reset, active low
//   m_cyc_i/m_stb_i/m_we_i in NM   per-master CYC/STB/WE
//   m_sel_i            in   NM*DW/8 per-master SEL, master k at [k*DW/8 +: DW/8]
//   m_adr_i            in   NM*AW   per-master address
//   m_dat_i            in   NM*DW   per-master write data
//   m_dat_o            out  DW      read data broadcast to all masters
//   m_ack_o/m_err_o    out  NM      ACK/ERR routed to the granted master only
//   gnt_o              out  NM      registered one-hot grant, 0 when idle
//   to_o               out  1       sticky watchdog flag
//   s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o  out  slave request
//   s_dat_i/s_ack_i/s_err_i                         in   slave response

module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NM = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned TO = 255
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM*DW/8-1:0] m_sel_i,
    input  logic [NM*AW-1:0]   m_adr_i,
    input  logic [NM*DW-1:0]   m_dat_i,
    output logic [DW-1:0]      m_dat_o,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [NM-1:0]      gnt_o,
    output logic               to_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [DW/8-1:0]    s_sel_o,
    output logic [AW-1:0]      s_adr_o,
    output logic [DW-1:0]      s_dat_o,
    input  logic [DW-1:0]      s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;

    arb_state_e    state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] gidx;
    logic [LW-1:0] pick_last;
    logic [NM-1:0] pick_gnt;
    logic          pick_any;
    logic          cur_cyc;
    logic          cur_stb;
    logic          abort;
    logic          tmo_err;

    // Index of the granted master (0 when idle; only used while busy).
    always_comb begin
        gidx = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (gnt_q[k]) gidx = LW'(k);
        end
    end

    assign cur_cyc = |(m_cyc_i & gnt_q);
    assign cur_stb = |(m_cyc_i & m_stb_i & gnt_q);

    // While busy the rotation starts after the current owner, so a release
    // hands over to the next requester at the same edge.
    assign pick_last = (state_q == StBusy) ? gidx : last_q;

    wb_rr_pick #(
        .NM (NM),
        .LW (LW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (pick_last),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!cur_cyc) begin
                    last_d = gidx;
                    if (pick_any) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= LW'(NM - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Slave-side mux; every field is zero when nothing is granted.
    always_comb begin
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (gnt_q[k]) begin
                s_we_o  = m_we_i[k];
                s_sel_o = m_sel_i[k*SW +: SW];
                s_adr_o = m_adr_i[k*AW +: AW];
                s_dat_o = m_dat_i[k*DW +: DW];
            end
        end
    end

    assign s_cyc_o = cur_cyc & ~abort;
    assign s_stb_o = cur_stb & ~abort;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = gnt_q & {NM{s_ack_i & s_stb_o}};
    assign m_err_o = gnt_q & {NM{(s_err_i & s_stb_o) | tmo_err}};
    assign gnt_o   = gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    logic          err_q;
    logic          to_q;
    logic          stall;
    logic          tmo_hit;

    assign stall   = cur_stb & ~abort_q & ~s_ack_i & ~s_err_i;
    assign tmo_hit = stall & (cnt_q == CW'(TO));

    always_comb begin
        cnt_d   = (stall && !tmo_hit) ? cnt_q + CW'(1) : '0;
        abort_d = abort_q;
        if (tmo_hit) begin
            abort_d = 1'b1;
        end else if (!cur_cyc) begin
            // Aborted master dropped CYC: normal release follows.
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= tmo_hit;
            to_q    <= to_q | tmo_hit;
        end
    end

    assign abort   = abort_q;
    assign tmo_err = err_q;
    assign to_o    = to_q;
`else
    logic [31:0] unused_to_limit;

    assign unused_to_limit = TO;
    assign abort           = 1'b0;
    assign tmo_err         = 1'b0;
    assign to_o            = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk;
    logic              arst;
    logic [NM-1:0]     cyc, stb, we;
    logic [NM*4-1:0]   sel;
    logic [NM*AW-1:0]  adr;
    logic [NM*DW-1:0]  wdat;
    logic [DW-1:0]     m_dat;
    logic [NM-1:0]     m_ack, m_err, gnt;
    logic              tmo;
    logic              s_cyc, s_stb, s_we;
    logic [3:0]        s_sel;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat, sdat;
    logic              sack, serr;

    int tests = 0;
    int fails = 0;

    // Reference model: current owner (-1 = none) and last released master.
    int m_cur;
    int m_last;

    wb_mem_arbiter #(
        .NM (NM),
        .AW (AW),
        .DW (DW),
        .TO (TO)
    ) dut (
        .clk_i   (clk),
        .arst_i  (arst),
        .m_cyc_i (cyc),
        .m_stb_i (stb),
        .m_we_i  (we),
        .m_sel_i (sel),
        .m_adr_i (adr),
        .m_dat_i (wdat),
        .m_dat_o (m_dat),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .gnt_o   (gnt),
        .to_o    (tmo),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_sel_o (s_sel),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat),
        .s_dat_i (sdat),
        .s_ack_i (sack),
        .s_err_i (serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic model_edge();
        int idx;
        if (!arst) begin
            m_cur  = -1;
            m_last = NM - 1;
        end else begin
            if (m_cur >= 0 && !cyc[m_cur]) begin
                m_last = m_cur;
                m_cur  = -1;
            end
            if (m_cur < 0) begin
                for (int k = 1; k <= NM; k++) begin
                    idx = (m_last + k) % NM;
                    if (m_cur < 0 && cyc[idx]) m_cur = idx;
                end
            end
        end
    endtask

    // One clock: model follows the active edge, caller resumes on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        arst = 1'b0;
        m_cur = -1;
        m_last = NM - 1;
        step();
        arst = 1'b1;
    endtask

    task automatic test_reset();
        arst = 1'b0; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0;
        sdat = '0; sack = 1'b0; serr = 1'b0;
        m_cur = -1; m_last = NM - 1;
        @(negedge clk);
        tests++;
        if (gnt !== 3'b000 || s_cyc !== 1'b0 || tmo !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: gnt=%b s_cyc=%b to=%b, required 000 0 0", gnt, s_cyc, tmo);
        end
        arst = 1'b1;
        cyc = 3'b010; stb = 3'b010; sack = 1'b1;
        step();
        tests++;
        if (gnt !== 3'b010 || s_stb !== 1'b1 || m_ack !== 3'b010) begin
            fails++;
            $display("FAIL reset_pre_busy: gnt=%b s_stb=%b ack=%b, required 010 1 010",
                     gnt, s_stb, m_ack);
        end
        #2;
        arst = 1'b0;
        m_cur = -1; m_last = NM - 1;
        #1;
        tests++;
        if (gnt !== 3'b000 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 3'b000
            || m_err !== 3'b000 || s_adr !== '0) begin
            fails++;
            $display("FAIL reset_async: gnt=%b cyc=%b stb=%b ack=%b err=%b, required all 0",
                     gnt, s_cyc, s_stb, m_ack, m_err);
        end
        @(negedge clk);
        step();
        arst = 1'b1;
        cyc = 3'b111; stb = 3'b111;
        step();
        tests++;
        if (gnt !== 3'b001) begin
            fails++;
            $display("FAIL reset_first_winner: gnt=%b, required 001", gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_seq [6];
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        cyc = '0; stb = '0; sack = 1'b1;
        pulse_reset();
        cyc = 3'b111; stb = 3'b111;
        #1;
        tests++;
        if (gnt !== 3'b000 || s_cyc !== 1'b0) begin
            fails++;
            $display("FAIL rr_latency: gnt=%b s_cyc=%b before edge, required 000 0", gnt, s_cyc);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (gnt !== exp_seq[i] || m_ack !== exp_seq[i] || s_cyc !== 1'b1) begin
                fails++;
                $display("FAIL rr_grant[%0d]: gnt=%b ack=%b s_cyc=%b, required %b %b 1",
                         i, gnt, m_ack, s_cyc, exp_seq[i], exp_seq[i]);
            end
            // Finished master drops; the one that dropped last cycle reissues.
            cyc = ~exp_seq[i];
            stb = ~exp_seq[i];
            step();
        end
        cyc = '0; stb = '0;
        step();
        tests++;
        if (gnt !== 3'b000) begin
            fails++;
            $display("FAIL rr_idle: gnt=%b, required 000", gnt);
        end
    endtask

    task automatic test_burst();
        logic [AW-1:0] a1;
        a1 = $urandom();
        adr = {$urandom(), a1, $urandom()};
        cyc = 3'b010; stb = 3'b010; sack = 1'b0;
        step();
        tests++;
        if (gnt !== 3'b010) begin
            fails++;
            $display("FAIL burst_grant: gnt=%b, required 010", gnt);
        end
        cyc = 3'b110; stb = 3'b110; sack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            tests++;
            if (gnt !== 3'b010 || m_ack !== 3'b010 || s_adr !== a1) begin
                fails++;
                $display("FAIL burst_beat[%0d]: gnt=%b ack=%b adr=%h, required 010 010 %h",
                         b, gnt, m_ack, s_adr, a1);
            end
            step();
        end
        cyc = 3'b100;
        #1;
        tests++;
        if (gnt !== 3'b010 || m_ack[2] !== 1'b0) begin
            fails++;
            $display("FAIL burst_hold: gnt=%b ack2=%b, required 010 0", gnt, m_ack[2]);
        end
        step();
        tests++;
        if (gnt !== 3'b100 || m_ack !== 3'b100) begin
            fails++;
            $display("FAIL burst_handoff: gnt=%b ack=%b, required 100 100", gnt, m_ack);
        end
        cyc = '0; stb = '0; sack = 1'b0;
        step();
    endtask

    task automatic test_read_err();
        logic [AW-1:0] a0;
        a0 = $urandom();
        adr = {64'h0, a0};
        cyc = 3'b001; stb = 3'b001; we = 3'b000;
        sdat = 32'hDEADBEEF; sack = 1'b1; serr = 1'b0;
        step();
        tests++;
        if (gnt !== 3'b001 || m_dat !== 32'hDEADBEEF || m_ack !== 3'b001 || m_err !== 3'b000
            || s_adr !== a0 || s_we !== 1'b0) begin
            fails++;
            $display("FAIL read_beat: gnt=%b dat=%h ack=%b err=%b adr=%h, required 001 deadbeef 001 000 %h",
                     gnt, m_dat, m_ack, m_err, s_adr, a0);
        end
        step();
        sack = 1'b0; serr = 1'b1;
        #1;
        tests++;
        if (m_err !== 3'b001 || m_ack !== 3'b000) begin
            fails++;
            $display("FAIL err_beat: err=%b ack=%b, required 001 000", m_err, m_ack);
        end
        step();
        serr = 1'b0; cyc = '0; stb = '0;
        step();
    endtask

    task automatic test_random();
        logic [NM-1:0] e_gnt;
        logic [70:0]   e_bus, a_bus;
        logic [5:0]    e_resp;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NM; k++) begin
                if (cyc[k]) cyc[k] = ($urandom_range(0, 3) != 0);
                else        cyc[k] = ($urandom_range(0, 2) == 0);
                stb[k]          = $urandom_range(0, 1);
                we[k]           = $urandom_range(0, 1);
                sel[k*4 +: 4]   = 4'($urandom());
                adr[k*AW +: AW] = $urandom();
                wdat[k*DW +: DW] = $urandom();
            end
            sack = ($urandom_range(0, 3) != 0);
            serr = !sack && ($urandom_range(0, 7) == 0);
            sdat = $urandom();
            #1;
            e_gnt = '0;
            e_bus = '0;
            e_resp = '0;
            if (m_cur >= 0) begin
                e_gnt[m_cur] = 1'b1;
                e_bus = {cyc[m_cur], cyc[m_cur] & stb[m_cur], we[m_cur], sel[m_cur*4 +: 4],
                         adr[m_cur*AW +: AW], wdat[m_cur*DW +: DW]};
                if (cyc[m_cur] && stb[m_cur]) e_resp = {e_gnt & {NM{sack}}, e_gnt & {NM{serr}}};
            end
            a_bus = {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat};
            tests++;
            if (gnt !== e_gnt) begin
                fails++;
                $display("FAIL rand_gnt[%0d]: gnt=%b, required %b", n, gnt, e_gnt);
            end
            tests++;
            if ({m_ack, m_err} !== e_resp || m_dat !== sdat) begin
                fails++;
                $display("FAIL rand_resp[%0d]: ack/err=%b dat=%h, required %b %h",
                         n, {m_ack, m_err}, m_dat, e_resp, sdat);
            end
            tests++;
            if (a_bus !== e_bus) begin
                fails++;
                $display("FAIL rand_bus[%0d]: slave=%h, required %h", n, a_bus, e_bus);
            end
            step();
        end
        cyc = '0; stb = '0; sack = 1'b0; serr = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        logic [NM-1:0] e_err;
        logic          e_to, e_stb;
        cyc = 3'b100; stb = 3'b100; sack = 1'b0; serr = 1'b0;
        step();
        for (int n = 0; n < 25; n++) begin
`ifdef WB_ARB_TIMEOUT_EN
            e_err = (n == TO + 1) ? 3'b100 : 3'b000;
            e_to  = (n >= TO + 1);
            e_stb = (n < TO + 1);
`else
            e_err = 3'b000;
            e_to  = 1'b0;
            e_stb = 1'b1;
`endif
            tests++;
            if (m_err !== e_err || tmo !== e_to || s_stb !== e_stb || gnt !== 3'b100) begin
                fails++;
                $display("FAIL timeout[%0d]: err=%b to=%b s_stb=%b gnt=%b, required %b %b %b 100",
                         n, m_err, tmo, s_stb, gnt, e_err, e_to, e_stb);
            end
            step();
        end
        cyc = '0; stb = '0;
        step();
        tests++;
        if (gnt !== 3'b000 || s_cyc !== 1'b0) begin
            fails++;
            $display("FAIL timeout_release: gnt=%b s_cyc=%b, required 000 0", gnt, s_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_read_err();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
